// File: rtl/i2s_stereo_serializer_if.sv
// Signal bundle between the sample source, the I2S serializer and the DAC
// pins. The serializer sits on the slave side: it receives the PCM sample
// and drives the request pulse and the three I2S pins.
interface i2s_stereo_serializer_if;
    logic [15:0] SAMPLE_IN;
    logic        REQ;
    logic        DAC_BCLK;
    logic        DAC_LRCLK;
    logic        DAC_DIN;

    modport master (
        output SAMPLE_IN,
        input  REQ,
        input  DAC_BCLK,
        input  DAC_LRCLK,
        input  DAC_DIN
    );

    modport slave (
        input  SAMPLE_IN,
        output REQ,
        output DAC_BCLK,
        output DAC_LRCLK,
        output DAC_DIN
    );
endinterface

// File: rtl/i2s_stereo_serializer.sv
// Philips I2S serializer. Divides CLK_DAC down to BCLK, walks a 32-slot
// frame and sends the same 16-bit sample on the left and right channels,
// MSB first, one BCLK after each LRCLK transition. A new sample is captured
// once per frame on the falling BCLK edge that enters slot 0, with REQ
// pulsed in that cycle. All pins come straight from registers.
module i2s_stereo_serializer #(
    parameter int unsigned BCLK_HALF_PERIOD = 8,
    parameter int unsigned SLOT_BITS        = 16
) (
    input  logic                    CLK_DAC,
    input  logic                    RESET_n,
    i2s_stereo_serializer_if.slave  io
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF_PERIOD - 1);
    // LRCLK is high while the new slot lies in 15..30: it switches one slot
    // ahead of the channel MSB it announces.
    localparam logic [4:0] LR_FIRST = 5'(SLOT_BITS - 1);
    localparam logic [4:0] LR_LAST  = 5'(2 * SLOT_BITS - 2);

    logic [7:0]  div_cnt_r;
    logic        bclk_r;
    logic [4:0]  slot_r;
    logic [15:0] hold_r;
    logic        din_r;
    logic        lrclk_r;
    logic        req_r;

    logic [7:0]  div_nxt_s;
    logic        bclk_nxt_s;
    logic        fall_s;
    logic [4:0]  slot_inc_s;
    logic [3:0]  bit_idx_s;
    logic        wrap_s;
    logic        din_nxt_s;
    logic        lr_nxt_s;

    // Divider, falling-edge detection and next-bit selection.
    always_comb begin
        div_nxt_s  = div_cnt_r + 8'd1;
        bclk_nxt_s = bclk_r;
        fall_s     = 1'b0;
        if (div_cnt_r == DIV_LAST) begin
            div_nxt_s  = 8'd0;
            bclk_nxt_s = ~bclk_r;
            fall_s     = bclk_r;
        end else begin
            div_nxt_s  = div_cnt_r + 8'd1;
        end

        slot_inc_s = slot_r + 5'd1;
        bit_idx_s  = 4'd15 - slot_inc_s[3:0];
        wrap_s     = (slot_inc_s == 5'd0);

        // Slot 0 takes its MSB straight from the sample being captured.
        if (wrap_s) begin
            din_nxt_s = io.SAMPLE_IN[15];
        end else begin
            din_nxt_s = hold_r[bit_idx_s];
        end

        lr_nxt_s = (slot_inc_s >= LR_FIRST) && (slot_inc_s <= LR_LAST);
    end

    // Divider, slot counter, sample hold and registered pin outputs.
    always_ff @(posedge CLK_DAC or negedge RESET_n) begin
        if (!RESET_n) begin
            div_cnt_r <= 8'd0;
            bclk_r    <= 1'b0;
            slot_r    <= 5'd31;
            hold_r    <= 16'd0;
            din_r     <= 1'b0;
            lrclk_r   <= 1'b0;
            req_r     <= 1'b0;
        end else begin
            div_cnt_r <= div_nxt_s;
            bclk_r    <= bclk_nxt_s;
            req_r     <= 1'b0;
            if (fall_s) begin
                slot_r  <= slot_inc_s;
                din_r   <= din_nxt_s;
                lrclk_r <= lr_nxt_s;
                if (wrap_s) begin
                    hold_r <= io.SAMPLE_IN;
                    req_r  <= 1'b1;
                end
            end
        end
    end

    assign io.REQ       = req_r;
    assign io.DAC_BCLK  = bclk_r;
    assign io.DAC_LRCLK = lrclk_r;
    assign io.DAC_DIN   = din_r;

endmodule

// File: tb/tb_i2s_stereo_serializer.sv
// Directed bench for the I2S serializer: one instance at BCLK_HALF_PERIOD=8
// and one at BCLK_HALF_PERIOD=1, sharing the clock with separate resets.
module tb_i2s_stereo_serializer;

    logic clk;
    logic rst_a_n;
    logic rst_b_n;
    int   total;
    int   bad;

    i2s_stereo_serializer_if ifa ();
    i2s_stereo_serializer_if ifb ();

    i2s_stereo_serializer #(.BCLK_HALF_PERIOD(8), .SLOT_BITS(16)) dut_a (
        .CLK_DAC (clk),
        .RESET_n (rst_a_n),
        .io      (ifa.slave)
    );

    i2s_stereo_serializer #(.BCLK_HALF_PERIOD(1), .SLOT_BITS(16)) dut_b (
        .CLK_DAC (clk),
        .RESET_n (rst_b_n),
        .io      (ifb.slave)
    );

    // Free-running CLK_DAC, period 10 time units.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] pins(input bit sel);
        if (sel) return {ifb.DAC_BCLK, ifb.DAC_LRCLK, ifb.DAC_DIN, ifb.REQ};
        else     return {ifa.DAC_BCLK, ifa.DAC_LRCLK, ifa.DAC_DIN, ifa.REQ};
    endfunction

    task automatic set_sample(input bit sel, input logic [15:0] v);
        if (sel) ifb.SAMPLE_IN = v;
        else     ifa.SAMPLE_IN = v;
    endtask

    // Starting just after a sampled REQ, follow one frame up to the next REQ.
    // DIN and LRCLK are collected at every BCLK rise, MSB (slot 0) first.
    task automatic run_frame(input bit sel,
                             input int c1_at, input logic [15:0] c1_v,
                             input int c2_at, input logic [15:0] c2_v,
                             output logic [31:0] din_w, output logic [31:0] lr_w,
                             output int len, output int lr_hi,
                             output int rises, output int lr_rise_at);
        logic [3:0] p;
        logic prev_b, prev_l;
        din_w = 32'd0; lr_w = 32'd0; len = 0; lr_hi = 0; rises = 0;
        lr_rise_at = -1; prev_b = 1'b0; prev_l = 1'b0;
        while (len < 2000) begin
            @(negedge clk);
            len++;
            if (len == c1_at) set_sample(sel, c1_v);
            if (len == c2_at) set_sample(sel, c2_v);
            p = pins(sel);
            if (p[3] && !prev_b) begin
                rises++;
                din_w = {din_w[30:0], p[1]};
                lr_w  = {lr_w[30:0], p[2]};
            end
            if (p[2]) lr_hi++;
            if (p[2] && !prev_l && lr_rise_at < 0) lr_rise_at = len;
            prev_b = p[3];
            prev_l = p[2];
            if (p[0]) break;
        end
    endtask

    task automatic frame_check(input bit sel, input string nm,
                               input int exp_len, input int exp_lr_hi, input int exp_rise,
                               input logic [31:0] exp_din,
                               input int c1_at, input logic [15:0] c1_v,
                               input int c2_at, input logic [15:0] c2_v);
        logic [31:0] din_w, lr_w;
        int len, lr_hi, rises, lr_rise_at;
        run_frame(sel, c1_at, c1_v, c2_at, c2_v, din_w, lr_w, len, lr_hi, rises, lr_rise_at);
        check({nm, "_req_period"}, len, exp_len);
        check({nm, "_bclk_rises"}, rises, 32);
        check({nm, "_lr_high"}, lr_hi, exp_lr_hi);
        check({nm, "_lr_rise_at"}, lr_rise_at, exp_rise);
        check({nm, "_din"}, din_w, exp_din);
        check({nm, "_lr_bits"}, lr_w, 32'h0001FFFE);
    endtask

    // Wait for the first REQ after a reset release; returns cycles elapsed.
    task automatic wait_req(input bit sel, output int first_rise, output int first_fall,
                            output int req_at);
        logic [3:0] p;
        logic prev_b;
        first_rise = -1; first_fall = -1; req_at = -1; prev_b = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            p = pins(sel);
            if (p[3] && !prev_b && first_rise < 0) first_rise = k;
            if (!p[3] && prev_b && first_fall < 0) first_fall = k;
            prev_b = p[3];
            if (p[0]) begin
                req_at = k;
                break;
            end
        end
    endtask

    initial begin
        int fr, ff, rq;
        total = 0;
        bad   = 0;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        ifa.SAMPLE_IN = 16'hA5C3;
        ifb.SAMPLE_IN = 16'h0001;

        repeat (3) @(negedge clk);
        check("reset_pins_a", {28'd0, pins(1'b0)}, 32'd0);
        check("reset_pins_b", {28'd0, pins(1'b1)}, 32'd0);

        // Release between clock edges and time the first BCLK edges.
        rst_a_n = 1'b1;
        wait_req(1'b0, fr, ff, rq);
        check("first_rise_a", fr, 8);
        check("first_fall_a", ff, 16);
        check("first_req_a", rq, 16);

        // Four free-running frames carrying A5C3 on both channels.
        for (int i = 0; i < 4; i++)
            frame_check(1'b0, $sformatf("free%0d", i), 512, 256, 240,
                        32'hA5C3A5C3, -1, 16'h0, -1, 16'h0);

        // Sample changes inside a frame must not disturb it.
        frame_check(1'b0, "chg_cur", 512, 256, 240, 32'hA5C3A5C3,
                    1, 16'h7FFF, 256, 16'h8000);
        frame_check(1'b0, "chg_next", 512, 256, 240, 32'h80008000,
                    -1, 16'h0, -1, 16'h0);

        // Reset in slot 20 (cycles 320..335 after REQ), where LRCLK is high.
        repeat (330) @(negedge clk);
        check("pre_rst_lr", {31'd0, ifa.DAC_LRCLK}, 32'd1);
        #2;
        rst_a_n = 1'b0;
        #1;
        check("async_rst_pins", {28'd0, pins(1'b0)}, 32'd0);
        ifa.SAMPLE_IN = 16'h1234;
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        wait_req(1'b0, fr, ff, rq);
        check("rst_first_req", rq, 16);
        frame_check(1'b0, "after_rst", 512, 256, 240, 32'h12341234,
                    -1, 16'h0, -1, 16'h0);

        // Fastest divider: BCLK = CLK_DAC/2, 64-cycle frames.
        rst_b_n = 1'b1;
        wait_req(1'b1, fr, ff, rq);
        check("first_rise_b", fr, 1);
        check("first_req_b", rq, 2);
        for (int i = 0; i < 2; i++)
            frame_check(1'b1, $sformatf("div1_%0d", i), 64, 32, 30,
                        32'h00010001, -1, 16'h0, -1, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_stereo_serializer.md
Name: i2s_stereo_serializer

Overview:
- Serial back end of the sound path. Accepts one 16-bit signed PCM sample per audio frame through a request/capture handshake, then shifts it out as a standard Philips I2S stream to the external DAC.
- Drives the same 16-bit sample on both left and right channels.
- Generates BCLK and LRCLK internally by dividing CLK_DAC, with no PLL or extra clock domain.
- Sits directly downstream of the sound-interface-to-16-bit adaptation stage and drives the DAC_BCLK, DAC_LRCLK and DAC_DIN pins.

Parameters:
- BCLK_HALF_PERIOD, 8, number of CLK_DAC cycles per BCLK half-period. Legal range 1..255.
- SLOT_BITS, 16, bits per channel slot. Fixed at 16; the frame is 32 BCLK periods.

Ports:
- CLK_DAC  input  1  single clock for the whole block.
- RESET_n  input  1  asynchronous, active-low reset.
- SAMPLE_IN  input  16  signed PCM sample, two's complement. Captured when REQ is high.
- REQ  output  1  one-CLK_DAC-cycle pulse. SAMPLE_IN is captured in this cycle; upstream may change SAMPLE_IN from the next cycle.
- DAC_BCLK  output  1  I2S bit clock. Period = 2*BCLK_HALF_PERIOD CLK_DAC cycles.
- DAC_LRCLK  output  1  I2S word select: 0 = left, 1 = right.
- DAC_DIN  output  1  I2S serial data, MSB first, changes on BCLK falling edge.

Behaviour:
- Reset, asynchronous and immediate:
  - DAC_BCLK=0, DAC_LRCLK=0, DAC_DIN=0, REQ=0.
  - Divider counter=0, slot counter=31, shift/hold register=0.
- Divider:
  - Counter runs 0..BCLK_HALF_PERIOD-1 and wraps.
  - At the terminal count, DAC_BCLK toggles.
  - The first rising edge occurs BCLK_HALF_PERIOD cycles after reset release.
- Falling-edge event is the cycle in which DAC_BCLK goes 1->0. All of the following are registered in that same cycle:
  - Slot counter (5-bit) increments and wraps 31->0.
  - DAC_DIN = bit (15 - slot mod 16) of the held sample, for the new slot value.
  - DAC_LRCLK = 1 when the new slot is in 15..30, else 0. LRCLK therefore leads the MSB of each channel by one BCLK (I2S delay).
- Sample capture:
  - On the falling-edge event entering slot 0, REQ=1 for that one cycle and SAMPLE_IN is loaded into the hold register.
  - DAC_DIN for slot 0 is taken from the newly loaded value, i.e. SAMPLE_IN[15] directly.
  - Right-channel slots 16..31 reuse the same held value.
- REQ timing:
  - REQ is never high on any other cycle.
  - Period is exactly 64*BCLK_HALF_PERIOD CLK_DAC cycles.
- No underflow state: if upstream has not updated SAMPLE_IN, the current value is captured again.
- DAC_DIN, DAC_LRCLK and DAC_BCLK are direct register outputs, with no combinational path from SAMPLE_IN.
- Stability: DIN and LRCLK are stable for BCLK_HALF_PERIOD cycles before each BCLK rising edge, where the DAC samples them.
- Mid-frame reset: all state returns to reset values. After release, the first frame starts cleanly at slot 0 with a fresh REQ. No partial frame is resumed.
- BCLK_HALF_PERIOD=1: BCLK toggles every cycle. The falling-edge event and capture rules are unchanged.

Test Plan:
- Reset with BCLK_HALF_PERIOD=8 -> all outputs 0 during reset. First DAC_BCLK rise 8 cycles after release, first fall at cycle 16 with REQ=1 in that same cycle.
- Free-run 4 frames -> BCLK period 16 cycles. REQ pulses exactly 1 cycle wide, every 512 cycles. LRCLK high for exactly 256 cycles per frame, rising 15 BCLK falls after each REQ.
- SAMPLE_IN=16'hA5C3 held -> DIN sampled on BCLK rises gives 1010010111000011 in the left slots and the same in the right slots, with LRCLK=0 then 1.
- Change SAMPLE_IN to 16'h7FFF one cycle after REQ, then to 16'h8000 mid-frame -> current frame still carries the old value. Next frame carries 16'h8000.
- Assert RESET_n low in slot 20 -> outputs go to 0 in the same cycle without a clock edge. After release, the first REQ comes 16 cycles later and the frame restarts at slot 0.
- BCLK_HALF_PERIOD=1, SAMPLE_IN=16'h0001 -> BCLK = CLK_DAC/2, REQ every 64 cycles. DIN is high only in slots 15 and 31.
